// File: rtl/alu_issue.sv
// ALU issue stage: RV32 OP/OP-IMM decode feeding a 2-entry in-order FIFO.
// Define ALU_ISSUE_SLT_EN to also decode SLT/SLTU/SLTI/SLTIU.
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  output logic [4:0]      rd,
  output logic            illegal
);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctrl;
    logic [4:0]      rd;
    logic            ill;
  } entry_t;

  localparam logic [3:0] C_ADD = 4'b0000;
  localparam logic [3:0] C_SUB = 4'b0001;
  localparam logic [3:0] C_AND = 4'b0010;
  localparam logic [3:0] C_OR  = 4'b0011;
  localparam logic [3:0] C_XOR = 4'b0100;
  localparam logic [3:0] C_SLL = 4'b0101;
  localparam logic [3:0] C_SRL = 4'b0110;
  localparam logic [3:0] C_SRA = 4'b0111;
`ifdef ALU_ISSUE_SLT_EN
  localparam logic [3:0] C_SLT  = 4'b1000;
  localparam logic [3:0] C_SLTU = 4'b1001;
`endif
  localparam logic [3:0] C_ILL = 4'b1111;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] F7_0    = 7'b0000000;
  localparam logic [6:0] F7_1    = 7'b0100000;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_op;
  logic       is_imm;
  logic [XLEN-1:0] imm_sx;
  logic [XLEN-1:0] shamt;
  logic       unused_rs1_idx;
  entry_t     dec;

  assign opc    = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign is_op  = (opc == OPC_OP);
  assign is_imm = (opc == OPC_IMM);
  assign imm_sx = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign shamt  = {{(XLEN-5){1'b0}}, in_instr[24:20]};
  assign unused_rs1_idx = ^in_instr[19:15];

  always_comb begin
    dec      = '0;
    dec.a    = in_rs1_val;
    dec.b    = in_rs2_val;
    dec.rd   = in_instr[11:7];
    dec.ctrl = C_ILL;
    unique case (1'b1)
      is_op: begin
        case ({f7, f3})
          {F7_0, 3'b000}: dec.ctrl = C_ADD;
          {F7_0, 3'b001}: dec.ctrl = C_SLL;
          {F7_0, 3'b100}: dec.ctrl = C_XOR;
          {F7_0, 3'b101}: dec.ctrl = C_SRL;
          {F7_0, 3'b110}: dec.ctrl = C_OR;
          {F7_0, 3'b111}: dec.ctrl = C_AND;
`ifdef ALU_ISSUE_SLT_EN
          {F7_0, 3'b010}: dec.ctrl = C_SLT;
          {F7_0, 3'b011}: dec.ctrl = C_SLTU;
`endif
          {F7_1, 3'b000}: dec.ctrl = C_SUB;
          {F7_1, 3'b101}: dec.ctrl = C_SRA;
          default: ;
        endcase
      end
      is_imm: begin
        dec.b = imm_sx;
        case (f3)
          3'b000: dec.ctrl = C_ADD;
          3'b100: dec.ctrl = C_XOR;
          3'b110: dec.ctrl = C_OR;
          3'b111: dec.ctrl = C_AND;
`ifdef ALU_ISSUE_SLT_EN
          3'b010: dec.ctrl = C_SLT;
          3'b011: dec.ctrl = C_SLTU;
`endif
          3'b001: begin
            dec.b = shamt;
            if (f7 == F7_0) dec.ctrl = C_SLL;
          end
          3'b101: begin
            dec.b = shamt;
            if (f7 == F7_0)      dec.ctrl = C_SRL;
            else if (f7 == F7_1) dec.ctrl = C_SRA;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    dec.ill = (dec.ctrl == C_ILL);
  end

  entry_t     mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // in_ready depends on registered count only
  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign alu_a    = mem[rd_ptr].a;
  assign alu_b    = mem[rd_ptr].b;
  assign alu_ctrl = mem[rd_ptr].ctrl;
  assign rd       = mem[rd_ptr].rd;
  assign illegal  = mem[rd_ptr].ill;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized bench for alu_issue against a queue-based reference model.
// Honors ALU_ISSUE_SLT_EN the same way the design does.
module tb_alu_issue;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

`ifdef ALU_ISSUE_SLT_EN
  localparam bit SLT_EN = 1'b1;
`else
  localparam bit SLT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Mnemonic-level decode: pick the operation from funct3, then vet funct7.
  function automatic exp_t ref_dec(logic [31:0] i, logic [31:0] a,
                                   logic [31:0] b);
    exp_t r;
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    bit op  = (i[6:0] == 7'h33);
    bit imm = (i[6:0] == 7'h13);
    bit shift = (f3 == 3'd1) || (f3 == 3'd5);
    bit alt_ok, f7_ok, slt_ok;
    logic [3:0] base;
    r.a = a; r.b = b; r.rd = i[11:7]; r.ctrl = 4'hF;
    if (op || imm) begin
      if (imm) r.b = shift ? {27'd0, i[24:20]} : {{20{i[31]}}, i[31:20]};
      case (f3)
        3'd0: base = (op && f7 == 7'h20) ? 4'd1 : 4'd0;
        3'd1: base = 4'd5;
        3'd2: base = 4'd8;
        3'd3: base = 4'd9;
        3'd4: base = 4'd4;
        3'd5: base = (f7 == 7'h20) ? 4'd7 : 4'd6;
        3'd6: base = 4'd3;
        default: base = 4'd2;
      endcase
      alt_ok = (op && f3 == 3'd0) || f3 == 3'd5;
      f7_ok  = (op || shift) ? (f7 == 7'h00 || (f7 == 7'h20 && alt_ok)) : 1'b1;
      slt_ok = (f3 == 3'd2 || f3 == 3'd3) ? SLT_EN : 1'b1;
      if (f7_ok && slt_ok) r.ctrl = base;
    end
    r.ill = (r.ctrl == 4'hF);
    return r;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] i = $urandom;
    int k = $urandom_range(0, 9);
    int s = $urandom_range(0, 3);
    if (k < 4)      i[6:0] = 7'h33;
    else if (k < 8) i[6:0] = 7'h13;
    if (s < 2)       i[31:25] = 7'h00;
    else if (s == 2) i[31:25] = 7'h20;
    return i;
  endfunction

  task automatic check_outs();
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("alu_a", alu_a, q[0].a);
      chk("alu_ctrl", alu_ctrl, q[0].ctrl);
      chk("rd", rd, q[0].rd);
      chk("illegal", illegal, q[0].ill);
      if (!q[0].ill) chk("alu_b", alu_b, q[0].b);
    end
  endtask

  // Check current outputs, advance the model, then clock once.
  task automatic cycle();
    bit push, pop;
    exp_t e;
    check_outs();
    push = in_valid && q.size() < 2 && !flush;
    pop  = q.size() > 0 && out_ready && !flush;
    e = ref_dec(in_instr, in_rs1_val, in_rs2_val);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drive(bit v, logic [31:0] i, logic [31:0] a,
                       logic [31:0] b, bit fl, bit ordy);
    in_valid = v; in_instr = i; in_rs1_val = a; in_rs2_val = b;
    flush = fl; out_ready = ordy;
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_instr = 0; in_rs1_val = 0; in_rs2_val = 0;
    flush = 0; out_ready = 0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_ctrl", alu_ctrl, 0);
    chk("rst_rd", rd, 0);
    chk("rst_illegal", illegal, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // add x3,x1,x2
    drive(1, 32'h002081B3, 32'd5, 32'd3, 0, 1);
    chk("add_a", alu_a, 32'd5);
    chk("add_b", alu_b, 32'd3);
    chk("add_ctrl", alu_ctrl, 4'b0000);
    chk("add_rd", rd, 5'd3);
    chk("add_ill", illegal, 0);
    // srai x5,x6,2 then addi x1,x0,-1
    drive(1, 32'h40235293, 32'hF000000F, 32'h1234, 0, 1);
    chk("srai_a", alu_a, 32'hF000000F);
    chk("srai_b", alu_b, 32'd2);
    chk("srai_ctrl", alu_ctrl, 4'b0111);
    chk("srai_rd", rd, 5'd5);
    drive(1, 32'hFFF00093, 32'd0, 32'h55, 0, 1);
    chk("addi_b", alu_b, 32'hFFFFFFFF);
    chk("addi_ctrl", alu_ctrl, 4'b0000);
    drive(0, 0, 0, 0, 0, 1);

    // backpressure: ADD then SUB held
    drive(1, 32'h002081B3, 32'd7, 32'd2, 0, 0);
    drive(1, 32'h402081B3, 32'd9, 32'd4, 0, 0);
    chk("full_in_ready", in_ready, 0);
    chk("full_head_ctrl", alu_ctrl, 4'b0000);
    drive(1, 32'h00000033, 32'd1, 32'd1, 0, 0);
    chk("hold_head_a", alu_a, 32'd7);
    drive(0, 0, 0, 0, 0, 1);
    chk("sub_ctrl", alu_ctrl, 4'b0001);
    chk("sub_a", alu_a, 32'd9);
    drive(0, 0, 0, 0, 0, 1);

    // lw illegal, then slt
    drive(1, 32'h0000A083, 32'd11, 32'd0, 0, 1);
    chk("lw_ill", illegal, 1);
    chk("lw_ctrl", alu_ctrl, 4'hF);
    chk("lw_a", alu_a, 32'd11);
    drive(1, 32'h0020A1B3, 32'd1, 32'd2, 0, 1);
    chk("slt_ctrl", alu_ctrl, SLT_EN ? 4'b1000 : 4'b1111);
    chk("slt_ill", illegal, !SLT_EN);
    drive(0, 0, 0, 0, 0, 1);

    // flush with two buffered and a live input
    drive(1, 32'h002081B3, 32'd1, 32'd1, 0, 0);
    drive(1, 32'h00208233, 32'd2, 32'd2, 0, 0);
    drive(1, 32'h0020C2B3, 32'hDEAD, 32'd3, 1, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 1);

    // async reset with one entry buffered
    drive(1, 32'h002081B3, 32'h77, 32'h1, 0, 0);
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_a", alu_a, 0);
    q.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 1);

    for (int k = 0; k < 600; k++)
      drive($urandom_range(0, 3) != 0, gen_instr(), $urandom, $urandom,
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
